// File: rtl/mul_err_sweep_ctrl_if.sv
// Operand/product bus between the sweep controller and the multiplier under test.
interface mul_err_sweep_ctrl_if #(
  parameter int unsigned WIDTH = 6
);
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] dut_prod;

  // Controller side: drives operands, receives the product.
  modport master (output op_a, output op_b, input dut_prod);
  // Multiplier side.
  modport slave (input op_a, input op_b, output dut_prod);
endinterface

// File: rtl/mul_err_sweep_ctrl.sv
// Exhaustive error sweep of an approximate WIDTH x WIDTH unsigned multiplier.
// Walks every operand pair one per clock, registers the returned product next
// to the exact product, and accumulates mismatch statistics one cycle later.
module mul_err_sweep_ctrl #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned CNT_W = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mul_err_sweep_ctrl_if.master mul,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_count,
  output logic [2*WIDTH-1:0]   max_err,
  output logic [ACC_W-1:0]     sum_err,
  output logic                 first_err_valid,
  output logic [WIDTH-1:0]     first_err_a,
  output logic [WIDTH-1:0]     first_err_b
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     index_q, index_d;
  logic              s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]  s1_a_q, s1_b_q;
  logic [PW-1:0]     s1_prod_q, s1_exact_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     max_q, max_d;
  logic [ACC_W-1:0]  sum_q, sum_d;
  logic              fv_q, fv_d;
  logic [WIDTH-1:0]  fa_q, fa_d, fb_q, fb_d;

  logic              capture;
  logic              clear_stats;
  logic              acc_en;
  logic [PW-1:0]     exact;
  logic [PW-1:0]     diff;
  logic [ACC_W:0]    sum_ext;

  assign mul.op_a = index_q[PW-1:WIDTH];
  assign mul.op_b = index_q[WIDTH-1:0];
  assign exact    = PW'(mul.op_a) * PW'(mul.op_b);

  // Absolute error at full product width; the extra sum bit detects saturation.
  assign diff    = (s1_prod_q >= s1_exact_q) ? (s1_prod_q - s1_exact_q)
                                             : (s1_exact_q - s1_prod_q);
  assign sum_ext = {1'b0, sum_q} + (ACC_W + 1)'(diff);

  // Abort discards the staged vector, so it also blocks accumulation.
  assign acc_en = s1_valid_q & ~abort;

  // Sequencer: next state, operand index and stage control.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    capture     = 1'b0;
    clear_stats = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          state_d     = StRun;
          index_d     = '0;
          clear_stats = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          capture = 1'b1;
          if (index_q == '1) begin
            state_d = StDrain;
          end else begin
            index_d = index_q + PW'(1);
          end
        end
      end
      StDrain: begin
        state_d = abort ? StIdle : StDone;
      end
      default: state_d = StIdle;
    endcase
    s1_valid_d = capture;
  end

  // Statistics update from the staged vector.
  always_comb begin
    cnt_d = cnt_q;
    max_d = max_q;
    sum_d = sum_q;
    fv_d  = fv_q;
    fa_d  = fa_q;
    fb_d  = fb_q;
    if (clear_stats) begin
      cnt_d = '0;
      max_d = '0;
      sum_d = '0;
      fv_d  = 1'b0;
      fa_d  = '0;
      fb_d  = '0;
    end else if (acc_en && (diff != '0)) begin
      cnt_d = cnt_q + CNT_W'(1);
      sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
      if (diff > max_q) begin
        max_d = diff;
      end
      if (!fv_q) begin
        fv_d = 1'b1;
        fa_d = s1_a_q;
        fb_d = s1_b_q;
      end
    end
  end

  // State, index, pipeline stage and accumulators.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      index_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_prod_q  <= '0;
      s1_exact_q <= '0;
      cnt_q      <= '0;
      max_q      <= '0;
      sum_q      <= '0;
      fv_q       <= 1'b0;
      fa_q       <= '0;
      fb_q       <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      s1_valid_q <= s1_valid_d;
      if (capture) begin
        s1_a_q     <= mul.op_a;
        s1_b_q     <= mul.op_b;
        s1_prod_q  <= mul.dut_prod;
        s1_exact_q <= exact;
      end
      cnt_q <= cnt_d;
      max_q <= max_d;
      sum_q <= sum_d;
      fv_q  <= fv_d;
      fa_q  <= fa_d;
      fb_q  <= fb_d;
    end
  end

  assign busy            = (state_q == StRun) || (state_q == StDrain);
  assign done            = (state_q == StDone);
  assign err_count       = cnt_q;
  assign max_err         = max_q;
  assign sum_err         = sum_q;
  assign first_err_valid = fv_q;
  assign first_err_a     = fa_q;
  assign first_err_b     = fb_q;

endmodule

// File: tb/tb_mul_err_sweep_ctrl.sv
// Bench for mul_err_sweep_ctrl: a WIDTH=6 and a WIDTH=3 instance, each checked
// every cycle against a sweep-level model, plus hand-computed end results.
module tb_mul_err_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] start_v;
  logic [1:0] abort_v;
  int         mode [2];
  int         n_checks;
  int         n_errors;

  // Sweep-level model of one controller instance.
  typedef struct {
    bit     act;
    bit     dn;
    int     k;
    int     idx;
    longint cnt;
    longint mx;
    longint sum;
    bit     fv;
    int     fa;
    int     fb;
  } mdl_t;

  mdl_t m [2];

  // Multiplier behaviours: 0 exact, 1 zero, 2 exact^1, 3 exact with bit5 cleared.
  function automatic int prod_fn(int md, int e);
    case (md)
      0:       return e;
      1:       return 0;
      2:       return e ^ 1;
      default: return e & ~32;
    endcase
  endfunction

  function automatic longint vec_err(int v, int w, int md);
    int a;
    int b;
    longint e;
    longint p;
    a = v >> w;
    b = v & ((1 << w) - 1);
    e = longint'(a * b);
    p = longint'(prod_fn(md, a * b));
    return (p > e) ? (p - e) : (e - p);
  endfunction

  function automatic int wof(int i);
    return (i == 0) ? 6 : 3;
  endfunction

  function automatic int accwof(int i);
    return (i == 0) ? 24 : 12;
  endfunction

  function automatic mdl_t mdl_clear();
    mdl_t z;
    z.act = 0; z.dn = 0; z.k = 0; z.idx = 0;
    z.cnt = 0; z.mx = 0; z.sum = 0; z.fv = 0; z.fa = 0; z.fb = 0;
    return z;
  endfunction

  // One clock of the model: vector v is accumulated v+2 cycles after start.
  function automatic mdl_t step(mdl_t s, int w, int accw, bit st, bit ab, int md);
    mdl_t   n;
    int     nv;
    int     v;
    longint d;
    longint sat;
    n   = s;
    nv  = 1 << (2 * w);
    sat = (longint'(1) << accw) - 1;
    if (s.act) begin
      if (ab) begin
        n.act = 0;
      end else begin
        n.k   = s.k + 1;
        n.idx = (n.k < nv) ? n.k : nv - 1;
        v     = n.k - 2;
        if (v >= 0 && v < nv) begin
          d = vec_err(v, w, md);
          if (d != 0) begin
            n.cnt = n.cnt + 1;
            n.sum = (n.sum + d > sat) ? sat : n.sum + d;
            if (d > n.mx) n.mx = d;
            if (!n.fv) begin
              n.fv = 1;
              n.fa = v >> w;
              n.fb = v & ((1 << w) - 1);
            end
          end
        end
        if (n.k == nv + 1) begin
          n.act = 0;
          n.dn  = 1;
        end
      end
    end else if (ab) begin
      n.dn = 0;
    end else if (st) begin
      n     = mdl_clear();
      n.act = 1;
    end
    return n;
  endfunction

  // DUT instances.
  mul_err_sweep_ctrl_if #(.WIDTH(6)) bus6 ();
  mul_err_sweep_ctrl_if #(.WIDTH(3)) bus3 ();

  assign bus6.dut_prod = 12'(prod_fn(mode[0], int'(bus6.op_a) * int'(bus6.op_b)));
  assign bus3.dut_prod = 6'(prod_fn(mode[1], int'(bus3.op_a) * int'(bus3.op_b)));

  logic        busy6, done6, fv6;
  logic [12:0] cnt6;
  logic [11:0] max6;
  logic [23:0] sum6;
  logic [5:0]  fa6, fb6;
  logic        busy3, done3, fv3;
  logic [6:0]  cnt3;
  logic [5:0]  max3;
  logic [11:0] sum3;
  logic [2:0]  fa3, fb3;

  mul_err_sweep_ctrl #(.WIDTH(6), .ACC_W(24), .CNT_W(13)) u_dut6 (
    .clk             (clk),
    .rst_n           (rst_n),
    .mul             (bus6.master),
    .start           (start_v[0]),
    .abort           (abort_v[0]),
    .busy            (busy6),
    .done            (done6),
    .err_count       (cnt6),
    .max_err         (max6),
    .sum_err         (sum6),
    .first_err_valid (fv6),
    .first_err_a     (fa6),
    .first_err_b     (fb6)
  );

  mul_err_sweep_ctrl #(.WIDTH(3), .ACC_W(12), .CNT_W(7)) u_dut3 (
    .clk             (clk),
    .rst_n           (rst_n),
    .mul             (bus3.master),
    .start           (start_v[1]),
    .abort           (abort_v[1]),
    .busy            (busy3),
    .done            (done3),
    .err_count       (cnt3),
    .max_err         (max3),
    .sum_err         (sum3),
    .first_err_valid (fv3),
    .first_err_a     (fa3),
    .first_err_b     (fb3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, longint got, longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Model advances on the same edges as the DUTs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= mdl_clear();
      m[1] <= mdl_clear();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m[i] <= step(m[i], wof(i), accwof(i), start_v[i], abort_v[i], mode[i]);
      end
    end
  end

  task automatic chk_inst(int i, longint bz, longint dn, longint oa, longint ob, longint c,
                          longint mx, longint s, longint fv, longint fa, longint fb);
    string p;
    int    w;
    p = (i == 0) ? "w6" : "w3";
    w = wof(i);
    chk({p, ".busy"}, bz, longint'(m[i].act));
    chk({p, ".done"}, dn, longint'(m[i].dn));
    chk({p, ".op_a"}, oa, longint'(m[i].idx >> w));
    chk({p, ".op_b"}, ob, longint'(m[i].idx & ((1 << w) - 1)));
    chk({p, ".err_count"}, c, m[i].cnt);
    chk({p, ".max_err"}, mx, m[i].mx);
    chk({p, ".sum_err"}, s, m[i].sum);
    chk({p, ".first_err_valid"}, fv, longint'(m[i].fv));
    chk({p, ".first_err_a"}, fa, longint'(m[i].fa));
    chk({p, ".first_err_b"}, fb, longint'(m[i].fb));
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk_inst(0, busy6, done6, bus6.op_a, bus6.op_b, cnt6, max6, sum6, fv6, fa6, fb6);
    chk_inst(1, busy3, done3, bus3.op_a, bus3.op_b, cnt3, max3, sum3, fv3, fa3, fb3);
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic logic get_busy(int i);
    return (i == 0) ? busy6 : busy3;
  endfunction

  function automatic logic get_done(int i);
    return (i == 0) ? done6 : done3;
  endfunction

  task automatic pulse_start(int i);
    start_v[i] = 1'b1;
    cyc(1);
    start_v[i] = 1'b0;
  endtask

  // Full sweep with a bounded wait; checks busy length and done.
  task automatic sweep(int i, int exp_cycles, string nm);
    int n;
    n = 0;
    pulse_start(i);
    while (get_busy(i) && n < exp_cycles + 50) begin
      n++;
      cyc(1);
    end
    chk({nm, ".busy_cycles"}, n, exp_cycles);
    chk({nm, ".done"}, get_done(i), 1);
  endtask

  task automatic stats6(string nm, longint c, longint mx, longint s, longint fv,
                        longint fa, longint fb);
    chk({nm, ".err_count"}, cnt6, c);
    chk({nm, ".max_err"}, max6, mx);
    chk({nm, ".sum_err"}, sum6, s);
    chk({nm, ".first_err_valid"}, fv6, fv);
    chk({nm, ".first_err_a"}, fa6, fa);
    chk({nm, ".first_err_b"}, fb6, fb);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    start_v  = '0;
    abort_v  = '0;
    mode[0]  = 0;
    mode[1]  = 0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    cyc(3);
    chk("reset.busy", busy6, 0);
    chk("reset.done", done6, 0);
    chk("reset.op_a", bus6.op_a, 0);
    stats6("reset", 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(2);

    // Loopback multiplier: no errors.
    mode[0] = 0;
    sweep(0, 4097, "t1");
    stats6("t1", 0, 0, 0, 0, 0, 0);

    // Product tied to zero.
    mode[0] = 1;
    sweep(0, 4097, "t2");
    stats6("t2", 3969, 3969, 4064256, 1, 1, 1);

    // Product off by one in the LSB everywhere.
    mode[0] = 2;
    sweep(0, 4097, "t3");
    stats6("t3", 4096, 1, 4096, 1, 0, 0);

    // Abort on the 100th RUN edge: vectors 0..97 accumulated, index held at 99.
    mode[0] = 1;
    pulse_start(0);
    cyc(99);
    abort_v[0] = 1'b1;
    cyc(1);
    abort_v[0] = 1'b0;
    chk("t4.busy", busy6, 0);
    chk("t4.done", done6, 0);
    chk("t4.op_a", bus6.op_a, 1);
    chk("t4.op_b", bus6.op_b, 35);
    stats6("t4", 33, 33, 561, 1, 1, 1);
    cyc(5);
    chk("t4.hold_err_count", cnt6, 33);
    chk("t4.hold_sum_err", sum6, 561);
    mode[0] = 0;
    sweep(0, 4097, "t4b");
    stats6("t4b", 0, 0, 0, 0, 0, 0);

    // Extra start while busy, then a reset mid-sweep.
    mode[0] = 2;
    pulse_start(0);
    cyc(10);
    pulse_start(0);
    cyc(1988);
    chk("t5.busy_before_reset", busy6, 1);
    rst_n = 1'b0;
    #1;
    chk("t5.busy", busy6, 0);
    chk("t5.done", done6, 0);
    chk("t5.op_a", bus6.op_a, 0);
    chk("t5.op_b", bus6.op_b, 0);
    stats6("t5", 0, 0, 0, 0, 0, 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(3);
    chk("t5.stay_idle", busy6, 0);
    mode[0] = 0;
    sweep(0, 4097, "t5b");
    stats6("t5b", 0, 0, 0, 0, 0, 0);

    // Narrow instance, product bit5 forced low: 5*7, 7*5, 6*6, 6*7, 7*6, 7*7 fail by 32.
    mode[1] = 3;
    sweep(1, 65, "t6");
    chk("t6.err_count", cnt3, 6);
    chk("t6.max_err", max3, 32);
    chk("t6.sum_err", sum3, 192);
    chk("t6.first_err_valid", fv3, 1);
    chk("t6.first_err_a", fa3, 5);
    chk("t6.first_err_b", fb3, 7);

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
